// File: rtl/eth_sb_core_req_queue.sv
// Request queue in front of eth_sb_axi_fsm: buffers host requests, issues them one at a time
// on the core_* interface, and returns one registered response per request.
module eth_sb_core_req_queue #(
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [DATA_WIDTH-1:0]   i_req_wdata,
  input  logic [3:0]              i_req_wstrb,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]              o_rsp_err,
  output logic                    o_rsp_write,
  output logic                    o_core_valid,
  output logic [ADDR_WIDTH-1:0]   o_core_addr,
  output logic [DATA_WIDTH-1:0]   o_core_wdata,
  output logic [3:0]              o_core_wstrb,
  input  logic                    i_core_ready,
  input  logic [DATA_WIDTH-1:0]   i_core_rdata,
  input  logic                    i_axi_slverr,
  output logic                    o_fifo_full,
  output logic                    o_fifo_empty,
  output logic [$clog2(DEPTH):0]  o_fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [LW-1:0] COUNT_FULL = LW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } state_t;

  logic [ADDR_WIDTH-1:0] r_memAddr  [DEPTH];
  logic [DATA_WIDTH-1:0] r_memWdata [DEPTH];
  logic [3:0]            r_memWstrb [DEPTH];

  logic [PW-1:0]         r_wrPtr;
  logic [PW-1:0]         r_rdPtr;
  logic [LW-1:0]         r_count;

  state_t                r_state;
  logic [TW-1:0]         r_timer;
  logic                  r_coreValid;
  logic [ADDR_WIDTH-1:0] r_coreAddr;
  logic [DATA_WIDTH-1:0] r_coreWdata;
  logic [3:0]            r_coreWstrb;
  logic                  r_rspValid;
  logic [DATA_WIDTH-1:0] r_rspRdata;
  logic [1:0]            r_rspErr;
  logic                  r_rspWrite;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_timeout;
  logic                  w_done;
  logic                  w_pop;

  assign w_full    = (r_count == COUNT_FULL);
  assign w_empty   = (r_count == '0);
  assign w_push    = i_req_valid && !w_full;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_timer == TIMER_LAST);
  assign w_done    = (r_state == S_ISSUE) && (i_core_ready || w_timeout);
  assign w_pop     = w_done;

  assign o_req_ready  = !w_full;
  assign o_fifo_full  = w_full;
  assign o_fifo_empty = w_empty;
  assign o_fifo_level = r_count;
  assign o_core_valid = r_coreValid;
  assign o_core_addr  = r_coreAddr;
  assign o_core_wdata = r_coreWdata;
  assign o_core_wstrb = r_coreWstrb;
  assign o_rsp_valid  = r_rspValid;
  assign o_rsp_rdata  = r_rspRdata;
  assign o_rsp_err    = r_rspErr;
  assign o_rsp_write  = r_rspWrite;

  // Storage needs no reset: only entries covered by r_count are ever read.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_memAddr[r_wrPtr]  <= i_req_addr;
      r_memWdata[r_wrPtr] <= i_req_wdata;
      r_memWstrb[r_wrPtr] <= i_req_wstrb;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The head stays counted while in flight and is popped on the completion edge.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_coreValid <= 1'b0;
      r_coreAddr  <= '0;
      r_coreWdata <= '0;
      r_coreWstrb <= '0;
      r_rspValid  <= 1'b0;
      r_rspRdata  <= '0;
      r_rspErr    <= 2'b00;
      r_rspWrite  <= 1'b0;
    end else begin
      if (r_rspValid && i_rsp_ready) r_rspValid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty && !r_rspValid) begin
            r_state     <= S_ISSUE;
            r_timer     <= '0;
            r_coreValid <= 1'b1;
            r_coreAddr  <= r_memAddr[r_rdPtr];
            r_coreWdata <= r_memWdata[r_rdPtr];
            r_coreWstrb <= r_memWstrb[r_rdPtr];
          end
        end
        S_ISSUE: begin
          if (w_done) begin
            r_rspValid  <= 1'b1;
            r_rspRdata  <= i_core_ready ? i_core_rdata : '0;
            r_rspErr    <= i_core_ready ? {1'b0, i_axi_slverr} : 2'b10;
            r_rspWrite  <= (r_coreWstrb != 4'h0);
            r_coreValid <= 1'b0;
            r_timer     <= '0;
            r_state     <= S_GAP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_GAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_sb_core_req_queue.sv
// Bench for eth_sb_core_req_queue: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a queue-based transaction model.
module tb_eth_sb_core_req_queue;

  localparam int AW    = 24;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TO    = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          reqValid;
  logic          reqReady;
  logic [AW-1:0] reqAddr;
  logic [DW-1:0] reqWdata;
  logic [3:0]    reqWstrb;
  logic          rspValid;
  logic          rspReady;
  logic [DW-1:0] rspRdata;
  logic [1:0]    rspErr;
  logic          rspWrite;
  logic          coreValid;
  logic [AW-1:0] coreAddr;
  logic [DW-1:0] coreWdata;
  logic [3:0]    coreWstrb;
  logic          coreReady;
  logic [DW-1:0] coreRdata;
  logic          slvErr;
  logic          fifoFull;
  logic          fifoEmpty;
  logic [2:0]    fifoLevel;

  int passCount = 0;
  int totalCount = 0;
  bit checkEn = 0;

  always #5 clk = ~clk;

  eth_sb_core_req_queue #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_req_valid(reqValid), .o_req_ready(reqReady),
    .i_req_addr(reqAddr), .i_req_wdata(reqWdata), .i_req_wstrb(reqWstrb),
    .o_rsp_valid(rspValid), .i_rsp_ready(rspReady),
    .o_rsp_rdata(rspRdata), .o_rsp_err(rspErr), .o_rsp_write(rspWrite),
    .o_core_valid(coreValid), .o_core_addr(coreAddr),
    .o_core_wdata(coreWdata), .o_core_wstrb(coreWstrb),
    .i_core_ready(coreReady), .i_core_rdata(coreRdata), .i_axi_slverr(slvErr),
    .o_fifo_full(fifoFull), .o_fifo_empty(fifoEmpty), .o_fifo_level(fifoLevel)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [3:0] s);
    reqValid = v;
    reqAddr  = a;
    reqWdata = d;
    reqWstrb = s;
  endtask

  // Transaction model: a plain queue of pending requests plus the one response slot.
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
  } req_t;

  req_t          mQ[$];
  bit            mIssuing = 0;
  bit            mGap = 0;
  int            mHeld = 0;
  bit            mRspValid = 0;
  logic [DW-1:0] mRspRdata = '0;
  logic [1:0]    mRspErr = '0;
  bit            mRspWrite = 0;

  always @(posedge clk) begin
    int   preSize;
    bit   accept, canIssue, finished;
    req_t r;
    if (!reset_n) begin
      mQ.delete();
      mIssuing  = 0;
      mGap      = 0;
      mHeld     = 0;
      mRspValid = 0;
    end else begin
      preSize  = mQ.size();
      accept   = reqValid && (preSize < DEPTH);
      canIssue = !mIssuing && !mGap && !mRspValid && (preSize > 0);
      finished = 0;
      if (mRspValid && rspReady) mRspValid = 0;
      if (mIssuing) begin
        if (coreReady) begin
          finished  = 1;
          mRspRdata = coreRdata;
          mRspErr   = {1'b0, slvErr};
        end else if (mHeld == TO) begin
          finished  = 1;
          mRspRdata = '0;
          mRspErr   = 2'b10;
        end else begin
          mHeld++;
        end
      end
      if (finished) begin
        mRspValid = 1;
        mRspWrite = (mQ[0].wstrb != 4'h0);
        void'(mQ.pop_front());
        mIssuing = 0;
      end
      mGap = finished;
      if (canIssue) begin
        mIssuing = 1;
        mHeld    = 1;
      end
      if (accept) begin
        r.addr  = reqAddr;
        r.wdata = reqWdata;
        r.wstrb = reqWstrb;
        mQ.push_back(r);
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("m_core_valid", 64'(coreValid), 64'(mIssuing));
      if (mIssuing && mQ.size() > 0) begin
        checkOutput("m_core_addr", 64'(coreAddr), 64'(mQ[0].addr));
        checkOutput("m_core_wdata", 64'(coreWdata), 64'(mQ[0].wdata));
        checkOutput("m_core_wstrb", 64'(coreWstrb), 64'(mQ[0].wstrb));
      end
      checkOutput("m_rsp_valid", 64'(rspValid), 64'(mRspValid));
      if (mRspValid) begin
        checkOutput("m_rsp_rdata", 64'(rspRdata), 64'(mRspRdata));
        checkOutput("m_rsp_err", 64'(rspErr), 64'(mRspErr));
        checkOutput("m_rsp_write", 64'(rspWrite), 64'(mRspWrite));
      end
      checkOutput("m_level", 64'(fifoLevel), 64'(mQ.size()));
      checkOutput("m_full", 64'(fifoFull), 64'(mQ.size() == DEPTH));
      checkOutput("m_empty", 64'(fifoEmpty), 64'(mQ.size() == 0));
      checkOutput("m_req_ready", 64'(reqReady), 64'(mQ.size() < DEPTH));
    end
  end

  initial begin
    int n;
    reset_n   = 1'b0;
    rspReady  = 1'b0;
    coreReady = 1'b0;
    coreRdata = '0;
    slvErr    = 1'b0;
    applyStimulus(1'b0, '0, '0, '0);
    tick();
    checkEn = 1;
    tick();
    tick();
    checkOutput("rst_core_valid", 64'(coreValid), 64'd0);
    checkOutput("rst_core_addr", 64'(coreAddr), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rspValid), 64'd0);
    checkOutput("rst_rsp_err", 64'(rspErr), 64'd0);
    checkOutput("rst_empty", 64'(fifoEmpty), 64'd1);
    checkOutput("rst_full", 64'(fifoFull), 64'd0);
    checkOutput("rst_req_ready", 64'(reqReady), 64'd1);
    reset_n = 1'b1;
    tick();

    // Read with ready on the third issue cycle.
    applyStimulus(1'b1, 24'h000010, 32'h0, 4'h0);
    tick();
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("rd_latency_low", 64'(coreValid), 64'd0);
    checkOutput("rd_level1", 64'(fifoLevel), 64'd1);
    tick();
    checkOutput("rd_issue", 64'(coreValid), 64'd1);
    checkOutput("rd_addr", 64'(coreAddr), 64'h10);
    tick();
    tick();
    coreReady = 1'b1;
    coreRdata = 32'hDEADBEEF;
    tick();
    coreReady = 1'b0;
    checkOutput("rd_core_drop", 64'(coreValid), 64'd0);
    checkOutput("rd_rsp_valid", 64'(rspValid), 64'd1);
    checkOutput("rd_rdata", 64'(rspRdata), 64'hDEADBEEF);
    checkOutput("rd_err", 64'(rspErr), 64'd0);
    checkOutput("rd_write", 64'(rspWrite), 64'd0);
    tick();
    checkOutput("rd_rsp_hold", 64'(rspRdata), 64'hDEADBEEF);
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    checkOutput("rd_rsp_clear", 64'(rspValid), 64'd0);

    // Write completing with a slave error.
    applyStimulus(1'b1, 24'h000020, 32'h12345678, 4'hF);
    tick();
    applyStimulus(1'b0, '0, '0, '0);
    tick();
    checkOutput("wr_wdata", 64'(coreWdata), 64'h12345678);
    coreReady = 1'b1;
    slvErr    = 1'b1;
    coreRdata = 32'hCAFEF00D;
    tick();
    coreReady = 1'b0;
    slvErr    = 1'b0;
    checkOutput("wr_err", 64'(rspErr), 64'd1);
    checkOutput("wr_write", 64'(rspWrite), 64'd1);
    checkOutput("wr_rdata", 64'(rspRdata), 64'hCAFEF00D);
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;

    // Five back-to-back pushes with no completion.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 24'h000100 + 24'(i), 32'(i), 4'h1);
      tick();
      if (i == 3) begin
        checkOutput("full_flag", 64'(fifoFull), 64'd1);
        checkOutput("full_level", 64'(fifoLevel), 64'd4);
        checkOutput("full_req_ready", 64'(reqReady), 64'd0);
      end
    end
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("full_fifth_held", 64'(fifoLevel), 64'd4);

    // Reset while a request is in flight.
    checkOutput("midrst_pre_valid", 64'(coreValid), 64'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checkOutput("midrst_core_valid", 64'(coreValid), 64'd0);
    checkOutput("midrst_empty", 64'(fifoEmpty), 64'd1);
    checkOutput("midrst_rsp_valid", 64'(rspValid), 64'd0);

    // Timeout followed by response backpressure.
    applyStimulus(1'b1, 24'h000040, 32'h0, 4'h0);
    tick();
    applyStimulus(1'b1, 24'h000044, 32'hA5A5A5A5, 4'h3);
    tick();
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("to_issue_addr", 64'(coreAddr), 64'h40);
    n = 0;
    while (coreValid && n < 20) begin
      n++;
      tick();
    end
    checkOutput("to_high_cycles", 64'(n), 64'd8);
    checkOutput("to_err", 64'(rspErr), 64'd2);
    checkOutput("to_rdata", 64'(rspRdata), 64'd0);
    checkOutput("to_rsp_valid", 64'(rspValid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("bp_no_issue", 64'(coreValid), 64'd0);
    end
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    checkOutput("bp_rsp_taken", 64'(rspValid), 64'd0);
    tick();
    checkOutput("bp_issue", 64'(coreValid), 64'd1);
    checkOutput("bp_addr", 64'(coreAddr), 64'h44);
    coreReady = 1'b1;
    coreRdata = 32'h55;
    tick();
    coreReady = 1'b0;
    checkOutput("bp_write", 64'(rspWrite), 64'd1);
    rspReady = 1'b1;
    tick();
    tick();

    // Random traffic, including stray core_ready outside issue and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      reset_n = ($urandom_range(0, 399) != 0);
      applyStimulus($urandom_range(0, 99) < 40, AW'($urandom), $urandom,
                    ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom));
      rspReady  = ($urandom_range(0, 99) < 50);
      coreReady = ($urandom_range(0, 99) < 25);
      coreRdata = $urandom;
      slvErr    = $urandom_range(0, 1) == 1;
      tick();
    end
    reset_n = 1'b1;
    applyStimulus(1'b0, '0, '0, '0);
    coreReady = 1'b0;
    tick();
    tick();
    checkEn = 0;

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
